// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-ASCII serializer.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  // Non-decimal nibbles become '?' so a corrupt word is visible on the line
  function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_ERR : (ASCII_ZERO + {4'h0, d});
  endfunction

endpackage

// File: rtl/bcd_ascii_ser_if.sv
// BCD word in / ASCII byte out handshake bundle for bcd_ascii_ser.
interface bcd_ascii_ser_if #(
  parameter int NUM_DIGITS = 10
);
  logic [4*NUM_DIGITS-1:0] bcd_data;
  logic                    bcd_valid;
  logic                    bcd_redy;
  logic [7:0]              ascii_data;
  logic                    ascii_valid;
  logic                    ascii_redy;

  // master: word producer and byte consumer; slave: the serializer
  modport master (output bcd_data, bcd_valid, ascii_redy,
                  input  bcd_redy, ascii_data, ascii_valid);
  modport slave  (input  bcd_data, bcd_valid, ascii_redy,
                  output bcd_redy, ascii_data, ascii_valid);
endinterface

// File: rtl/bcd_lead_digit.sv
// Priority encoder: index of the most significant non-zero BCD nibble.
module bcd_lead_digit #(
  parameter int NUM_DIGITS = 10,
  parameter int IDXW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic [4*NUM_DIGITS-1:0] i_word,
  output logic [IDXW-1:0]         o_idx,
  output logic                    o_zero
);

  // Ascending scan: the last non-zero nibble hit is the most significant one
  always_comb begin
    o_idx  = '0;
    o_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_word[4*i +: 4] != 4'd0) begin
        o_idx  = IDXW'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_ascii_ser.sv
// Serializes a packed BCD word into ASCII digits followed by CR/LF.
// Define BCD_ASCII_LZB_EN to blank leading zeros (all-zero word sends one '0').
module bcd_ascii_ser
  import bcd_pkg::*;
#(
  parameter int         NUM_DIGITS = 10,
  parameter logic [7:0] EOL_CR     = 8'h0D,
  parameter logic [7:0] EOL_LF     = 8'h0A
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_data_i,
  input  logic                    bcd_data_valid_i,
  output logic                    bcd_redy_o,
  output logic [7:0]              ascii_data_o,
  output logic                    ascii_data_valid_o,
  input  logic                    ascii_redy_i
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                  r_state, w_state_nxt;
  logic [4*NUM_DIGITS-1:0] r_word, w_word_nxt;
  logic [IDXW-1:0]         r_idx, w_idx_nxt, w_start, w_idx_dn;
  logic [7:0]              r_data, w_data_nxt;
  logic                    r_valid, w_valid_nxt, r_redy;
  logic                    w_accept, w_xfer;
  logic [3:0]              w_nib_first, w_nib_next;

  assign w_accept = bcd_data_valid_i & r_redy;
  assign w_xfer   = r_valid & ascii_redy_i;

`ifdef BCD_ASCII_LZB_EN
  logic [IDXW-1:0] w_lead;
  logic            w_zero;

  bcd_lead_digit #(.NUM_DIGITS(NUM_DIGITS), .IDXW(IDXW)) u_lead (
    .i_word (bcd_data_i),
    .o_idx  (w_lead),
    .o_zero (w_zero)
  );

  assign w_start = w_zero ? '0 : w_lead;
`else
  assign w_start = IDXW'(NUM_DIGITS - 1);
`endif

  // First byte comes straight off the input so it is ready one clock after accept
  assign w_nib_first = 4'(bcd_data_i >> (4 * w_start));
  assign w_idx_dn    = r_idx - IDXW'(1);
  assign w_nib_next  = 4'(r_word >> (4 * w_idx_dn));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = DIGIT;
        w_word_nxt  = bcd_data_i;
        w_idx_nxt   = w_start;
        w_data_nxt  = bcd2ascii(w_nib_first);
        w_valid_nxt = 1'b1;
      end
      DIGIT: if (w_xfer) begin
        if (r_idx == '0) begin
          w_state_nxt = CR;
          w_data_nxt  = EOL_CR;
        end else begin
          w_idx_nxt  = w_idx_dn;
          w_data_nxt = bcd2ascii(w_nib_next);
        end
      end
      CR: if (w_xfer) begin
        w_state_nxt = LF;
        w_data_nxt  = EOL_LF;
      end
      LF: if (w_xfer) begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Ready is registered off the next state, so it rises the cycle after the LF transfer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_redy  <= 1'b0;
    end else begin
      r_word  <= w_word_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_redy  <= (w_state_nxt == IDLE);
    end
  end

  assign bcd_redy_o         = r_redy;
  assign ascii_data_o       = r_data;
  assign ascii_data_valid_o = r_valid;

endmodule

// File: tb/tb_bcd_ascii_ser.sv
// Self-checking bench for bcd_ascii_ser: fixed vectors, backpressure, reset, random words.
module tb_bcd_ascii_ser;

`ifdef BCD_ASCII_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [39:0] word;
    int          n;
    logic [95:0] bytes;
  } vec_t;

  logic clk;
  logic rstn;
  bcd_ascii_ser_if #(.NUM_DIGITS(10)) bus();

  bcd_ascii_ser #(.NUM_DIGITS(10), .EOL_CR(8'h0D), .EOL_LF(8'h0A)) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .bcd_data_i         (bus.bcd_data),
    .bcd_data_valid_i   (bus.bcd_valid),
    .bcd_redy_o         (bus.bcd_redy),
    .ascii_data_o       (bus.ascii_data),
    .ascii_data_valid_o (bus.ascii_valid),
    .ascii_redy_i       (bus.ascii_redy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mode = 0;
  int          pidx = 0;
  logic [3:0]  pat = 4'b1001;
  logic [7:0]  got[$];
  int          stamps[$];
  logic [7:0]  exp_q[$];
  vec_t        tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: record transfers, check hold-under-backpressure, drive ascii_redy
  task automatic step();
    logic       pv, pr;
    logic [7:0] pd;
    pv = bus.ascii_valid; pr = bus.ascii_redy; pd = bus.ascii_data;
    @(posedge clk); #1;
    cyc++;
    if (rstn && pv && pr) begin
      got.push_back(pd);
      stamps.push_back(cyc);
    end
    if (rstn && pv && !pr) chk("hold", {55'd0, bus.ascii_valid, bus.ascii_data}, {55'd0, 1'b1, pd});
    if (bus.ascii_valid) chk("redy_only_idle", {63'd0, bus.bcd_redy}, 64'd0);
    case (mode)
      0:       bus.ascii_redy = 1'b1;
      1:       begin bus.ascii_redy = pat[pidx % 4]; pidx++; end
      default: bus.ascii_redy = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Reference: decimal digits by division, optional blanking, then CR LF
  task automatic model(input logic [39:0] w);
    longint unsigned v;
    int d[10];
    int start;
    bit found;
    v = 64'(w);
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      d[i] = int'(v % 16);
      v = v / 16;
    end
    start = 9;
    if (LZB) begin
      start = 0; found = 1'b0;
      for (int i = 9; i >= 0; i--)
        if (!found && d[i] != 0) begin start = i; found = 1'b1; end
    end
    for (int i = start; i >= 0; i--)
      exp_q.push_back(d[i] > 9 ? 8'h3F : 8'(48 + d[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send(input logic [39:0] w, output int acc);
    int t;
    t = 0;
    while (!bus.bcd_redy && t < 50) begin step(); t++; end
    chk("accept_ready", {63'd0, bus.bcd_redy}, 64'd1);
    bus.bcd_data = w; bus.bcd_valid = 1'b1; pidx = 0;
    step();
    acc = cyc;
    bus.bcd_valid = 1'b0;
    bus.bcd_data = 40'({$urandom(), $urandom()});
  endtask

  task automatic run(input logic [39:0] w, input int md, input string nm);
    int acc, t, n;
    mode = md;
    got.delete(); stamps.delete();
    n = exp_q.size();
    send(w, acc);
    t = 0;
    while (got.size() < n && t < 400) begin step(); t++; end
    chk({nm, " count"}, 64'(got.size()), 64'(n));
    for (int k = 0; k < n; k++)
      if (k < got.size()) chk($sformatf("%s byte%0d", nm, k), {56'd0, got[k]}, {56'd0, exp_q[k]});
    chk({nm, " redy_after_lf"}, {62'd0, bus.bcd_redy, bus.ascii_valid}, 64'd2);
    if (md == 0 && got.size() == n) begin
      chk({nm, " latency"}, 64'(stamps[0]), 64'(acc + 1));
      chk({nm, " back_to_back"}, 64'(stamps[n-1]), 64'(acc + n));
    end
    step(); step();
    chk({nm, " no_extra"}, 64'(got.size()), 64'(n));
  endtask

  initial begin
    int t;
    int acc;
    logic [39:0] w;
`ifdef BCD_ASCII_LZB_EN
    tbl[0] = '{40'h0000012345, 7,  {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A, 40'h0}};
    tbl[1] = '{40'h0000000000, 3,  {8'h30, 8'h0D, 8'h0A, 72'h0}};
    tbl[3] = '{40'h000000000A, 3,  {8'h3F, 8'h0D, 8'h0A, 72'h0}};
`else
    tbl[0] = '{40'h0000012345, 12, {{5{8'h30}}, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A}};
    tbl[1] = '{40'h0000000000, 12, {{10{8'h30}}, 8'h0D, 8'h0A}};
    tbl[3] = '{40'h000000000A, 12, {{9{8'h30}}, 8'h3F, 8'h0D, 8'h0A}};
`endif
    tbl[2] = '{40'h4294967295, 12, {8'h34, 8'h32, 8'h39, 8'h34, 8'h39, 8'h36, 8'h37, 8'h32,
                                    8'h39, 8'h35, 8'h0D, 8'h0A}};
    tbl[4] = '{40'hB000000001, 12, {8'h3F, {8{8'h30}}, 8'h31, 8'h0D, 8'h0A}};

    rstn = 1'b1;
    bus.bcd_valid = 1'b0; bus.bcd_data = '0; bus.ascii_redy = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) step();
    chk("rst_valid", {63'd0, bus.ascii_valid}, 64'd0);
    chk("rst_redy",  {63'd0, bus.bcd_redy}, 64'd0);
    chk("rst_data",  {56'd0, bus.ascii_data}, 64'd0);
    rstn = 1'b1;
    #1 chk("redy_before_edge", {63'd0, bus.bcd_redy}, 64'd0);
    step();
    chk("redy_first_edge", {63'd0, bus.bcd_redy}, 64'd1);

    // Fixed vectors at full rate
    for (int j = 0; j < 5; j++) begin
      exp_q.delete();
      for (int k = 0; k < tbl[j].n; k++) exp_q.push_back(tbl[j].bytes[95 - 8*k -: 8]);
      run(tbl[j].word, 0, $sformatf("vec%0d", j));
    end

    // Backpressure 1,0,0,1 repeating
    exp_q.delete();
    for (int k = 0; k < tbl[0].n; k++) exp_q.push_back(tbl[0].bytes[95 - 8*k -: 8]);
    run(tbl[0].word, 1, "bp_vec0");
    model(40'h9081726354);
    run(40'h9081726354, 1, "bp_mixed");

    // Reset after the third transferred byte
    model(40'h0000012345);
    mode = 0; got.delete(); stamps.delete();
    send(40'h0000012345, acc);
    t = 0;
    while (got.size() < 3 && t < 50) begin step(); t++; end
    chk("rst_mid_pre_bytes", 64'(got.size()), 64'd3);
    #1 rstn = 1'b0;
    #1 chk("rst_mid_outputs", {54'd0, bus.ascii_valid, bus.bcd_redy, bus.ascii_data}, 64'd0);
    repeat (3) step();
    rstn = 1'b1;
    got.delete();
    repeat (20) step();
    chk("rst_mid_no_leftover", 64'(got.size()), 64'd0);
    model(40'h4294967295);
    run(40'h4294967295, 0, "post_rst");

    // Random words with random downstream stalls
    for (int r = 0; r < 40; r++) begin
      int k;
      k = $urandom_range(0, 10);
      w = '0;
      for (int i = 0; i < 10; i++)
        if (i < 10 - k)
          w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      model(w);
      run(w, 2, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
